// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: opcode constants, the decode-stage
// FSM state type and the ID/EX operand bundle.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ALUI_LO = 6'h08;
    localparam logic [5:0] OP_ALUI_HI = 6'h0F;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [ADDR_W-1:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_DECODE,
        ST_STALL,
        ST_HOLD
    } id_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] dst;
        logic [5:0]        op;
        logic [5:0]        funct;
        logic              wb_en;
        logic              mem_rd;
        logic              mem_wr;
    } id_ex_t;

    // rt is read by R-type ALU ops, stores and the two compare branches.
    function automatic logic rt_is_source(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    // Instructions that produce a register result.
    function automatic logic writes_reg(input logic [5:0] op);
        return (op == OP_RTYPE) || (op >= OP_ALUI_LO && op <= OP_ALUI_HI) ||
               (op == OP_LW) || (op == OP_JAL);
    endfunction

    // Logical immediates are zero-extended, everything else sign-extended.
    function automatic logic imm_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Combinational operand resolution for the decode stage: decides which
// sources are live, picks each operand from zero / bypass / register file
// and raises a stall when a live source is not yet available.
// Build option: ID_FORWARD_EN compiles in the mem_fwd and wb bypass paths;
// without it any pending producer in mem_fwd or wb stalls instead.
module id_hazard_unit
    import mips_pkg::*;
(
    input  logic [5:0]        op,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    input  logic              slot_valid,
    input  logic              slot_wb_en,
    input  logic [ADDR_W-1:0] slot_dst,
    input  logic              mem_fwd_en,
    input  logic [ADDR_W-1:0] mem_fwd_addr,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              stall
);

    // Index 0 is rs, index 1 is rt.
    logic [1:0][ADDR_W-1:0] src_addr;
    logic [1:0][DATA_W-1:0] src_rf;
    logic [1:0]             src_used;
    logic [1:0][DATA_W-1:0] src_val;
    logic [1:0]             src_stall;

    assign src_addr = {rt, rs};
    assign src_rf   = {rf_data_b, rf_data_a};
    assign src_used = {rt_is_source(op), 1'b1};

    // Per-source priority select: $0, ID/EX producer (stall), mem_fwd, wb, register file.
    always_comb begin
        // NOTE: every output gets a default before the branches so no path leaves it unassigned (no latch).
        src_val   = src_rf;
        src_stall = '0;
        for (int i = 0; i < 2; i++) begin
            if (src_addr[i] == '0) begin
                src_val[i] = '0;
            end else if (slot_valid && slot_wb_en && slot_dst == src_addr[i]) begin
                // Result still being computed (ALU) or fetched (load): wait.
                src_stall[i] = src_used[i];
`ifdef ID_FORWARD_EN
            end else if (mem_fwd_en && mem_fwd_addr == src_addr[i]) begin
                src_val[i] = mem_fwd_data;
            end else if (wb_en && wb_addr == src_addr[i]) begin
                src_val[i] = wb_data;
`else
            end else if ((mem_fwd_en && mem_fwd_addr == src_addr[i]) ||
                         (wb_en && wb_addr == src_addr[i])) begin
                // No bypass: wait until the register file holds the value.
                src_stall[i] = src_used[i];
`endif
            end
        end
    end

`ifndef ID_FORWARD_EN
    logic [DATA_W-1:0] unused_fwd_data;
    assign unused_fwd_data = mem_fwd_data ^ wb_data;
`endif

    assign op_a  = src_val[0];
    assign op_b  = src_val[1];
    assign stall = |src_stall;

endmodule

// File: rtl/id_stage.sv
// Instruction-decode / operand-fetch stage: IF/ID latch, decode, hazard
// resolution and a registered ID/EX bundle with a valid/ready handshake.
// Build option: ID_FORWARD_EN enables the mem_fwd / wb bypass paths.
module id_stage
    import mips_pkg::*;
(
    input  logic              elk,
    input  logic              nrst,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc,
    output logic              id_ready,
    output logic [ADDR_W-1:0] rd_addrA,
    output logic [ADDR_W-1:0] rd_addrB,
    input  logic [DATA_W-1:0] rd_dataA,
    input  logic [DATA_W-1:0] rd_dataB,
    input  logic              mem_fwd_en,
    input  logic [ADDR_W-1:0] mem_fwd_addr,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_dst,
    output logic [5:0]        ex_op,
    output logic [5:0]        ex_funct,
    output logic              ex_wb_en,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr
);

    id_state_e         state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    id_ex_t            out_q, out_d;
    logic              ex_valid_q, ex_valid_d;

    logic [5:0]        op, funct;
    logic [ADDR_W-1:0] rs, rt, rd;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] op_a, op_b;
    logic              hazard, advance, issue;
    id_ex_t            dec;

    // Latch validity is encoded in the FSM: only EMPTY means no instruction.
    assign op    = instr_q[31:26];
    assign rs    = instr_q[25:21];
    assign rt    = instr_q[20:16];
    assign rd    = instr_q[15:11];
    assign funct = instr_q[5:0];
    assign imm16 = instr_q[15:0];

    logic unused_shamt;
    assign unused_shamt = ^instr_q[10:6];

    assign rd_addrA = rs;
    assign rd_addrB = rt;
    assign advance  = !ex_valid_q || ex_ready;

    id_hazard_unit u_hazard (
        .op           (op),
        .rs           (rs),
        .rt           (rt),
        .rf_data_a    (rd_dataA),
        .rf_data_b    (rd_dataB),
        .slot_valid   (ex_valid_q),
        .slot_wb_en   (out_q.wb_en),
        .slot_dst     (out_q.dst),
        .mem_fwd_en   (mem_fwd_en),
        .mem_fwd_addr (mem_fwd_addr),
        .mem_fwd_data (mem_fwd_data),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .op_a         (op_a),
        .op_b         (op_b),
        .stall        (hazard)
    );

    // Decode the latched instruction into a candidate ID/EX bundle.
    always_comb begin
        dec        = '0;
        dec.pc     = pc_q;
        dec.op_a   = op_a;
        dec.op_b   = op_b;
        dec.imm    = imm_zero_ext(op) ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
        dec.dst    = (op == OP_RTYPE) ? rd : ((op == OP_JAL) ? REG_RA : rt);
        dec.op     = op;
        dec.funct  = funct;
        dec.wb_en  = writes_reg(op);
        dec.mem_rd = (op == OP_LW);
        dec.mem_wr = (op == OP_SW);
    end

    // FSM state register.
    always_ff @(posedge elk or negedge nrst) begin
        if (!nrst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: backpressure (HOLD) outranks a stall; otherwise refill or drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: state_d = if_valid ? ST_DECODE : ST_EMPTY;
            ST_DECODE, ST_STALL, ST_HOLD: begin
                if (!advance)      state_d = ST_HOLD;
                else if (hazard)   state_d = ST_STALL;
                else if (if_valid) state_d = ST_DECODE;
                else               state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // FSM outputs: accept from fetch and issue to execute.
    always_comb begin
        id_ready = 1'b1;
        issue    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                id_ready = 1'b1;
                issue    = 1'b0;
            end
            default: begin
                id_ready = advance && !hazard;
                issue    = !hazard;
            end
        endcase
    end

    // Next values of the IF/ID latch and the ID/EX register.
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        out_d      = out_q;
        ex_valid_d = ex_valid_q;
        if (id_ready && if_valid) begin
            instr_d = if_instr;
            pc_d    = if_pc;
        end
        if (advance) begin
            ex_valid_d = issue;
            out_d      = issue ? dec : '0;
        end
    end

    // Pipeline registers; reset drops any partial bundle.
    always_ff @(posedge elk or negedge nrst) begin
        if (!nrst) begin
            instr_q    <= '0;
            pc_q       <= '0;
            out_q      <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            out_q      <= out_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_pc     = out_q.pc;
    assign ex_opA    = out_q.op_a;
    assign ex_opB    = out_q.op_b;
    assign ex_imm    = out_q.imm;
    assign ex_dst    = out_q.dst;
    assign ex_op     = out_q.op;
    assign ex_funct  = out_q.funct;
    assign ex_wb_en  = out_q.wb_en;
    assign ex_mem_rd = out_q.mem_rd;
    assign ex_mem_wr = out_q.mem_wr;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage with a small register-file model.
// Expected values follow the default or ID_FORWARD_EN build.
module tb_id_stage;

    logic        elk;
    logic        nrst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic [4:0]  rd_addrA;
    logic [4:0]  rd_addrB;
    logic [31:0] rd_dataA;
    logic [31:0] rd_dataB;
    logic        mem_fwd_en;
    logic [4:0]  mem_fwd_addr;
    logic [31:0] mem_fwd_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_opA;
    logic [31:0] ex_opB;
    logic [31:0] ex_imm;
    logic [4:0]  ex_dst;
    logic [5:0]  ex_op;
    logic [5:0]  ex_funct;
    logic        ex_wb_en;
    logic        ex_mem_rd;
    logic        ex_mem_wr;

    logic [31:0] regs [32];
    int          errors = 0;
    int          checks = 0;

    localparam logic [31:0] I_ADDU3  = 32'h00221821; // addu $3,$1,$2
    localparam logic [31:0] I_ORI4   = 32'h34048001; // ori  $4,$0,0x8001
    localparam logic [31:0] I_ADDI4  = 32'h20048001; // addi $4,$0,0x8001
    localparam logic [31:0] I_LW5    = 32'h8C250000; // lw   $5,0($1)
    localparam logic [31:0] I_ADDU6  = 32'h00A53021; // addu $6,$5,$5
    localparam logic [31:0] I_ADDU7  = 32'h00223821; // addu $7,$1,$2
    localparam logic [31:0] I_ORI8   = 32'h34080001; // ori  $8,$0,1
    localparam logic [31:0] I_ORI9   = 32'h34090002; // ori  $9,$0,2
    localparam logic [31:0] I_ORI10  = 32'h340A0003; // ori  $10,$0,3
    localparam logic [31:0] I_ADDU13 = 32'h00606821; // addu $13,$3,$0
    localparam logic [31:0] I_SW     = 32'hAC220004; // sw   $2,4($1)
    localparam logic [31:0] I_JAL    = 32'h0C000010; // jal  0x10

    id_stage dut (
        .elk          (elk),
        .nrst         (nrst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .id_ready     (id_ready),
        .rd_addrA     (rd_addrA),
        .rd_addrB     (rd_addrB),
        .rd_dataA     (rd_dataA),
        .rd_dataB     (rd_dataB),
        .mem_fwd_en   (mem_fwd_en),
        .mem_fwd_addr (mem_fwd_addr),
        .mem_fwd_data (mem_fwd_data),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_pc        (ex_pc),
        .ex_opA       (ex_opA),
        .ex_opB       (ex_opB),
        .ex_imm       (ex_imm),
        .ex_dst       (ex_dst),
        .ex_op        (ex_op),
        .ex_funct     (ex_funct),
        .ex_wb_en     (ex_wb_en),
        .ex_mem_rd    (ex_mem_rd),
        .ex_mem_wr    (ex_mem_wr)
    );

    initial elk = 1'b0;
    always #5 elk = ~elk;

    assign rd_dataA = regs[rd_addrA];
    assign rd_dataB = regs[rd_addrB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge elk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
        regs[0] = 32'h0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[5] = 32'h55;

        nrst = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_ready = 1'b1;
        mem_fwd_en = 1'b0; mem_fwd_addr = '0; mem_fwd_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        // Reset state
        #3;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_rd_addrA", rd_addrA, 0);
        check("rst_rd_addrB", rd_addrB, 0);
        check("rst_id_ready", id_ready, 1);
        check("rst_ex_opA", ex_opA, 0);
        tick(); tick();
        nrst = 1'b1;

        // addu $3,$1,$2: two edges to reach execute
        if_valid = 1'b1; if_instr = I_ADDU3; if_pc = 32'h100;
        tick();
        if_valid = 1'b0;
        settle();
        check("addu_rd_addrA", rd_addrA, 1);
        check("addu_rd_addrB", rd_addrB, 2);
        check("addu_not_yet", ex_valid, 0);
        tick();
        check("addu_valid", ex_valid, 1);
        check("addu_opA", ex_opA, 5);
        check("addu_opB", ex_opB, 7);
        check("addu_dst", ex_dst, 3);
        check("addu_wb_en", ex_wb_en, 1);
        check("addu_pc", ex_pc, 32'h100);
        check("addu_funct", ex_funct, 6'h21);

        // Zero- vs sign-extended immediates, back to back
        if_valid = 1'b1; if_instr = I_ORI4; if_pc = 32'h104;
        tick();
        if_instr = I_ADDI4; if_pc = 32'h108;
        tick();
        check("ori_valid", ex_valid, 1);
        check("ori_imm", ex_imm, 32'h00008001);
        check("ori_opA", ex_opA, 0);
        check("ori_dst", ex_dst, 4);
        check("ori_pc", ex_pc, 32'h104);
        if_valid = 1'b0;
        tick();
        check("addi_valid", ex_valid, 1);
        check("addi_imm", ex_imm, 32'hFFFF8001);
        check("addi_pc", ex_pc, 32'h108);

        // Load-use: lw $5 then addu $6,$5,$5
        if_valid = 1'b1; if_instr = I_LW5; if_pc = 32'h10C;
        tick();
        if_instr = I_ADDU6; if_pc = 32'h110;
        tick();
        if_valid = 1'b0;
        settle();
        check("lw_mem_rd", ex_mem_rd, 1);
        check("lw_dst", ex_dst, 5);
        check("lw_opA", ex_opA, 5);
        check("lw_imm", ex_imm, 0);
        check("lu_id_ready", id_ready, 0);
        tick();
        check("lu_bubble", ex_valid, 0);
        mem_fwd_en = 1'b1; mem_fwd_addr = 5'd5; mem_fwd_data = 32'h1234;
`ifdef ID_FORWARD_EN
        settle();
        check("lu_ready_fwd", id_ready, 1);
        tick();
        mem_fwd_en = 1'b0;
        regs[5] = 32'h1234;
`else
        tick();
        check("lu_bubble2", ex_valid, 0);
        mem_fwd_en = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        tick();
        check("lu_bubble3", ex_valid, 0);
        wb_en = 1'b0;
        regs[5] = 32'h1234;
        tick();
`endif
        check("lu_valid", ex_valid, 1);
        check("lu_opA", ex_opA, 32'h1234);
        check("lu_opB", ex_opB, 32'h1234);
        check("lu_dst", ex_dst, 6);
        check("lu_pc", ex_pc, 32'h110);

        // Same-cycle writeback of $2 beats the stale register file value
        if_valid = 1'b1; if_instr = I_ADDU7; if_pc = 32'h114;
        tick();
        if_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hABCD;
`ifdef ID_FORWARD_EN
        tick();
        wb_en = 1'b0;
        regs[2] = 32'hABCD;
`else
        settle();
        check("wb_stall_ready", id_ready, 0);
        tick();
        wb_en = 1'b0;
        regs[2] = 32'hABCD;
        check("wb_bubble", ex_valid, 0);
        tick();
`endif
        check("wb_valid", ex_valid, 1);
        check("wb_opB", ex_opB, 32'hABCD);
        check("wb_opA", ex_opA, 5);
        check("wb_dst", ex_dst, 7);

        // Backpressure for three cycles with a stream behind it
        ex_ready = 1'b0;
        if_valid = 1'b1; if_instr = I_ORI8; if_pc = 32'h118;
        settle();
        check("bp_ready_empty", id_ready, 1);
        tick();
        if_instr = I_ORI9; if_pc = 32'h11C;
        settle();
        check("bp_ready_0", id_ready, 0);
        check("bp_hold1_pc", ex_pc, 32'h114);
        tick();
        check("bp_hold2_pc", ex_pc, 32'h114);
        check("bp_hold2_valid", ex_valid, 1);
        tick();
        check("bp_hold3_pc", ex_pc, 32'h114);
        check("bp_hold3_dst", ex_dst, 7);
        check("bp_hold3_ready", id_ready, 0);
        ex_ready = 1'b1;
        settle();
        check("bp_release_ready", id_ready, 1);
        tick();
        check("bp_i8_dst", ex_dst, 8);
        check("bp_i8_imm", ex_imm, 1);
        check("bp_i8_pc", ex_pc, 32'h118);
        if_instr = I_ORI10; if_pc = 32'h120;
        tick();
        check("bp_i9_dst", ex_dst, 9);
        check("bp_i9_pc", ex_pc, 32'h11C);
        if_valid = 1'b0;
        tick();
        check("bp_i10_dst", ex_dst, 10);
        check("bp_i10_pc", ex_pc, 32'h120);
        tick();
        check("bp_no_dup", ex_valid, 0);

        // Reset pulsed while stalled on an ALU dependency
        if_valid = 1'b1; if_instr = I_ADDU3; if_pc = 32'h200;
        tick();
        if_instr = I_ADDU13; if_pc = 32'h204;
        tick();
        if_valid = 1'b0;
        settle();
        check("stall_prod_valid", ex_valid, 1);
        check("stall_id_ready", id_ready, 0);
        nrst = 1'b0;
        settle();
        check("mid_rst_valid", ex_valid, 0);
        check("mid_rst_opA", ex_opA, 0);
        check("mid_rst_dst", ex_dst, 0);
        check("mid_rst_rd_addrA", rd_addrA, 0);
        check("mid_rst_id_ready", id_ready, 1);
        tick();
        nrst = 1'b1;
        tick();
        check("post_rst_no_bundle", ex_valid, 0);
        if_valid = 1'b1; if_instr = I_SW; if_pc = 32'h300;
        tick();
        if_valid = 1'b0;
        tick();
        check("sw_valid", ex_valid, 1);
        check("sw_opA", ex_opA, 5);
        check("sw_opB", ex_opB, 32'hABCD);
        check("sw_imm", ex_imm, 4);
        check("sw_mem_wr", ex_mem_wr, 1);
        check("sw_wb_en", ex_wb_en, 0);
        check("sw_pc", ex_pc, 32'h300);

        // JAL writes $31
        if_valid = 1'b1; if_instr = I_JAL; if_pc = 32'h304;
        tick();
        if_valid = 1'b0;
        tick();
        check("jal_dst", ex_dst, 31);
        check("jal_wb_en", ex_wb_en, 1);
        check("jal_op", ex_op, 6'h03);
        check("jal_imm", ex_imm, 32'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
